// File: rtl/fv_bank_router_if.sv
// Request-FIFO and bank-controller signal bundle for fv_bank_router.
// The master side is the router; the slave side is the FIFO and bank environment.
interface fv_bank_router_if #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 8,
  parameter int TAG_W     = 4
);
  localparam int BANK_SEL_W  = $clog2(NUM_BANKS);
  localparam int BANK_ADDR_W = ADDR_W - BANK_SEL_W;

  logic                   fifo_empty;
  logic                   fifo_rinc;
  logic                   fifo_valid;
  logic [ADDR_W-1:0]      fifo_addr;
  logic [TAG_W-1:0]       fifo_tag;
  logic [NUM_BANKS-1:0]   bank_busy;
  logic [NUM_BANKS-1:0]   bank_valid;
  logic [BANK_ADDR_W-1:0] bank_addr;
  logic [TAG_W-1:0]       bank_tag;
  logic                   req_drop;
  logic                   stall_err;
  logic                   router_busy;

  modport master (
    input  fifo_empty, fifo_valid, fifo_addr, fifo_tag, bank_busy,
    output fifo_rinc, bank_valid, bank_addr, bank_tag, req_drop, stall_err, router_busy
  );

  modport slave (
    output fifo_empty, fifo_valid, fifo_addr, fifo_tag, bank_busy,
    input  fifo_rinc, bank_valid, bank_addr, bank_tag, req_drop, stall_err, router_busy
  );
endinterface

// File: rtl/fv_bank_router.sv
// Feature-vector request router: pops the request FIFO, decodes the bank from the top
// address bits and issues one-cycle valid pulses, holding a blocked entry until its bank frees.
module fv_bank_router #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 8,
  parameter int TAG_W     = 4,
  parameter int STALL_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  fv_bank_router_if.master bus
);
  localparam int BANK_SEL_W  = $clog2(NUM_BANKS);
  localparam int BANK_ADDR_W = ADDR_W - BANK_SEL_W;
  localparam int CNT_W       = $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0]     STALL_MAX_C = CNT_W'(STALL_MAX);
  localparam logic [NUM_BANKS-1:0] BANK_ONE    = NUM_BANKS'(1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t                 r_state;
  logic [BANK_SEL_W-1:0]  r_hold_sel;
  logic [BANK_ADDR_W-1:0] r_hold_addr;
  logic [TAG_W-1:0]       r_hold_tag;
  logic [CNT_W-1:0]       r_stall_cnt;
  logic [NUM_BANKS-1:0]   r_bank_valid;
  logic [BANK_ADDR_W-1:0] r_bank_addr;
  logic [TAG_W-1:0]       r_bank_tag;
  logic                   r_req_drop;
  logic                   r_stall_err;
  logic                   r_router_busy;

  logic                   w_in_hold;
  logic [BANK_SEL_W-1:0]  w_sel;
  logic [BANK_ADDR_W-1:0] w_addr;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_have;
  logic                   w_blocked;
  logic                   w_issue;
  logic                   w_park;
  logic                   w_drop;
  logic                   w_pop;
  state_t                 w_next;

  // The candidate entry comes from the hold register in HOLD, otherwise straight off the FIFO.
  assign w_in_hold = (r_state == HOLD);
  assign w_sel     = w_in_hold ? r_hold_sel  : bus.fifo_addr[ADDR_W-1 -: BANK_SEL_W];
  assign w_addr    = w_in_hold ? r_hold_addr : bus.fifo_addr[BANK_ADDR_W-1:0];
  assign w_tag     = w_in_hold ? r_hold_tag  : bus.fifo_tag;

  // Busy from a bank lags our issue by a cycle, so last cycle's pulse also blocks that bank.
  assign w_blocked = bus.bank_busy[w_sel] | r_bank_valid[w_sel];
  assign w_have    = w_in_hold | ((r_state == WAIT) & bus.fifo_valid);
  assign w_issue   = w_have & ~w_blocked;
  assign w_park    = w_have & w_blocked;
  assign w_drop    = (r_state == WAIT) & ~bus.fifo_valid;
  assign w_pop     = reset & ~bus.fifo_empty & ((r_state == IDLE) | w_issue | w_drop);

  assign w_next = w_park ? HOLD : (w_pop ? WAIT : IDLE);

  // NOTE: every register below, including the hold entry and the watchdog counter, is
  // cleared by the async reset, and all state updates use non-blocking assignments so
  // each one sees the pre-edge value of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_hold_sel    <= '0;
      r_hold_addr   <= '0;
      r_hold_tag    <= '0;
      r_stall_cnt   <= '0;
      r_bank_valid  <= '0;
      r_bank_addr   <= '0;
      r_bank_tag    <= '0;
      r_req_drop    <= 1'b0;
      r_stall_err   <= 1'b0;
      r_router_busy <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_req_drop    <= w_drop;
      r_router_busy <= (w_next != IDLE);
      r_bank_valid  <= '0;

      if (w_issue) begin
        r_bank_valid <= BANK_ONE << w_sel;
        r_bank_addr  <= w_addr;
        r_bank_tag   <= w_tag;
      end

      if (w_park && !w_in_hold) begin
        r_hold_sel  <= w_sel;
        r_hold_addr <= w_addr;
        r_hold_tag  <= w_tag;
        r_stall_cnt <= '0;
      end else if (w_park && r_stall_cnt != STALL_MAX_C) begin
        // Saturating count of blocked HOLD cycles; the flag is sticky until reset.
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        if (r_stall_cnt + CNT_W'(1) == STALL_MAX_C) r_stall_err <= 1'b1;
      end
    end
  end

  assign bus.fifo_rinc   = w_pop;
  assign bus.bank_valid  = r_bank_valid;
  assign bus.bank_addr   = r_bank_addr;
  assign bus.bank_tag    = r_bank_tag;
  assign bus.req_drop    = r_req_drop;
  assign bus.stall_err   = r_stall_err;
  assign bus.router_busy = r_router_busy;
endmodule

// File: tb/tb_fv_bank_router.sv
// Scoreboard bench for fv_bank_router: a 4-bank instance with a short watchdog and an
// 8-bank/10-bit instance for the async-reset case, each fed by a small FIFO model.
module tb_fv_bank_router;
  typedef struct packed { logic v; logic [9:0] addr; logic [3:0] tag; } ent_t;
  typedef struct packed { logic [7:0] bv; logic [9:0] ba; logic [3:0] tag; } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  ent_t a_fq[$], b_fq[$];
  exp_t a_exp[$], b_exp[$];
  int   a_pops[$], a_issues[$], a_drops[$];
  int   b_pops[$], b_issues[$];

  fv_bank_router_if #(.NUM_BANKS(4), .ADDR_W(8),  .TAG_W(4)) a_if ();
  fv_bank_router_if #(.NUM_BANKS(8), .ADDR_W(10), .TAG_W(4)) b_if ();

  fv_bank_router #(.NUM_BANKS(4), .ADDR_W(8), .TAG_W(4), .STALL_MAX(4)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if)
  );
  fv_bank_router #(.NUM_BANKS(8), .ADDR_W(10), .TAG_W(4), .STALL_MAX(255)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic req(input bit to_b, input logic v, input logic [9:0] addr, input logic [3:0] tag,
                     input bit exp_issue, input logic [7:0] bv, input logic [9:0] ba);
    ent_t e;
    exp_t x;
    e.v = v; e.addr = addr; e.tag = tag;
    x.bv = bv; x.ba = ba; x.tag = tag;
    if (to_b) begin
      b_fq.push_back(e);
      if (exp_issue) b_exp.push_back(x);
    end else begin
      a_fq.push_back(e);
      if (exp_issue) a_exp.push_back(x);
    end
  endtask

  task automatic wait_a_issues(input int n);
    for (int i = 0; i < 40 && a_issues.size() < n; i++) step();
    check("a_issue_wait", 32'(a_issues.size() >= n), 32'd1);
  endtask

  task automatic wait_a_pops(input int n);
    for (int i = 0; i < 40 && a_pops.size() < n; i++) step();
    check("a_pop_wait", 32'(a_pops.size() >= n), 32'd1);
  endtask

  task automatic wait_b_issues(input int n);
    for (int i = 0; i < 40 && b_issues.size() < n; i++) step();
    check("b_issue_wait", 32'(b_issues.size() >= n), 32'd1);
  endtask

  task automatic wait_b_pops(input int n);
    for (int i = 0; i < 40 && b_pops.size() < n; i++) step();
    check("b_pop_wait", 32'(b_pops.size() >= n), 32'd1);
  endtask

  task automatic clear_logs();
    a_pops.delete(); a_issues.delete(); a_drops.delete();
    b_pops.delete(); b_issues.delete();
  endtask

  // FIFO models: a pop seen in cycle t presents its entry during t+1.
  initial begin : fifo_a
    ent_t e;
    bit   pop;
    a_if.fifo_empty = 1'b1; a_if.fifo_valid = 1'b0; a_if.fifo_addr = '0; a_if.fifo_tag = '0;
    forever begin
      @(negedge clk);
      pop = (a_if.fifo_rinc === 1'b1);
      if (pop) a_pops.push_back(cyc);
      @(posedge clk);
      #1;
      a_if.fifo_valid = 1'b0;
      if (pop && a_fq.size() > 0) begin
        e = a_fq.pop_front();
        a_if.fifo_valid = e.v;
        a_if.fifo_addr  = e.addr[7:0];
        a_if.fifo_tag   = e.tag;
      end
      a_if.fifo_empty = (a_fq.size() == 0);
    end
  end

  initial begin : fifo_b
    ent_t e;
    bit   pop;
    b_if.fifo_empty = 1'b1; b_if.fifo_valid = 1'b0; b_if.fifo_addr = '0; b_if.fifo_tag = '0;
    forever begin
      @(negedge clk);
      pop = (b_if.fifo_rinc === 1'b1);
      if (pop) b_pops.push_back(cyc);
      @(posedge clk);
      #1;
      b_if.fifo_valid = 1'b0;
      if (pop && b_fq.size() > 0) begin
        e = b_fq.pop_front();
        b_if.fifo_valid = e.v;
        b_if.fifo_addr  = e.addr;
        b_if.fifo_tag   = e.tag;
      end
      b_if.fifo_empty = (b_fq.size() == 0);
    end
  end

  // Monitors: pop the scoreboard whenever an issue pulse appears.
  initial begin : mon_a
    exp_t       x;
    logic [3:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (a_if.bank_valid != '0) begin
        a_issues.push_back(cyc);
        check("a_onehot", 32'($onehot(a_if.bank_valid)), 32'd1);
        check("a_no_repeat", 32'(a_if.bank_valid & prev), 32'd0);
        if (a_exp.size() == 0) check("a_spurious_issue", 32'(a_if.bank_valid), 32'd0);
        else begin
          x = a_exp.pop_front();
          check("a_bank_valid", 32'(a_if.bank_valid), 32'(x.bv));
          check("a_bank_addr",  32'(a_if.bank_addr),  32'(x.ba));
          check("a_bank_tag",   32'(a_if.bank_tag),   32'(x.tag));
        end
      end
      if (a_if.req_drop === 1'b1) a_drops.push_back(cyc);
      prev = a_if.bank_valid;
    end
  end

  initial begin : mon_b
    exp_t       x;
    logic [7:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (b_if.bank_valid != '0) begin
        b_issues.push_back(cyc);
        check("b_onehot", 32'($onehot(b_if.bank_valid)), 32'd1);
        check("b_no_repeat", 32'(b_if.bank_valid & prev), 32'd0);
        if (b_exp.size() == 0) check("b_spurious_issue", 32'(b_if.bank_valid), 32'd0);
        else begin
          x = b_exp.pop_front();
          check("b_bank_valid", 32'(b_if.bank_valid), 32'(x.bv));
          check("b_bank_addr",  32'(b_if.bank_addr),  32'(x.ba));
          check("b_bank_tag",   32'(b_if.bank_tag),   32'(x.tag));
        end
      end
      prev = b_if.bank_valid;
    end
  end

  initial begin : stim
    int p;
    int b;
    n_checks = 0; n_pass = 0; cyc = 0;
    reset = 1'b1;
    a_if.bank_busy = '0;
    b_if.bank_busy = '0;
    #1 reset = 1'b0;

    // Reset state, with a request already waiting so the pop strobe must be held off.
    req(0, 1'b1, 10'h0C5, 4'd3, 1, 8'h08, 10'h05);
    repeat (3) step();
    check("rst_bank_valid",  32'(a_if.bank_valid),  32'd0);
    check("rst_bank_addr",   32'(a_if.bank_addr),   32'd0);
    check("rst_bank_tag",    32'(a_if.bank_tag),    32'd0);
    check("rst_req_drop",    32'(a_if.req_drop),    32'd0);
    check("rst_stall_err",   32'(a_if.stall_err),   32'd0);
    check("rst_router_busy", 32'(a_if.router_busy), 32'd0);
    check("rst_fifo_rinc",   32'(a_if.fifo_rinc),   32'd0);

    // Single request to bank 3: pop at t, issue at t+2, busy only while not IDLE.
    @(posedge clk);
    #2 reset = 1'b1;
    step();
    check("t1_popped", 32'(a_pops.size()), 32'd1);
    step();
    check("t1_busy_in_wait", 32'(a_if.router_busy), 32'd1);
    wait_a_issues(1);
    check("t1_latency", 32'(a_issues[0] - a_pops[0]), 32'd2);
    check("t1_busy_after", 32'(a_if.router_busy), 32'd0);
    repeat (2) step();
    clear_logs();

    // Four requests to banks 0..3 stream out one per cycle.
    req(0, 1'b1, 10'h001, 4'd1, 1, 8'h01, 10'h01);
    req(0, 1'b1, 10'h042, 4'd2, 1, 8'h02, 10'h02);
    req(0, 1'b1, 10'h083, 4'd3, 1, 8'h04, 10'h03);
    req(0, 1'b1, 10'h0C4, 4'd4, 1, 8'h08, 10'h04);
    wait_a_issues(4);
    check("t2_pop_count", 32'(a_pops.size()), 32'd4);
    check("t2_pop_span", 32'(a_pops[3] - a_pops[0]), 32'd3);
    check("t2_first_latency", 32'(a_issues[0] - a_pops[0]), 32'd2);
    check("t2_issue_span", 32'(a_issues[3] - a_issues[0]), 32'd3);
    repeat (3) step();
    clear_logs();

    // Back-to-back requests to bank 2: shadow interlock spaces them by two cycles.
    req(0, 1'b1, 10'h085, 4'd5, 1, 8'h04, 10'h05);
    req(0, 1'b1, 10'h0BA, 4'd6, 1, 8'h04, 10'h3A);
    wait_a_issues(2);
    check("t3_pop_gap", 32'(a_pops[1] - a_pops[0]), 32'd1);
    check("t3_issue_gap", 32'(a_issues[1] - a_issues[0]), 32'd2);
    repeat (3) step();
    clear_logs();

    // Invalid returned entry: one drop pulse, next entry still issues.
    req(0, 1'b0, 10'h0FF, 4'd8, 0, 8'h00, 10'h00);
    req(0, 1'b1, 10'h047, 4'd9, 1, 8'h02, 10'h07);
    wait_a_issues(1);
    check("t4_pop_count", 32'(a_pops.size()), 32'd2);
    check("t4_drop_count", 32'(a_drops.size()), 32'd1);
    if (a_drops.size() > 0) check("t4_drop_cycle", 32'(a_drops[0] - a_pops[0]), 32'd2);
    check("t4_issue_cycle", 32'(a_issues[0] - a_pops[0]), 32'd3);
    repeat (3) step();
    clear_logs();

    // Bank 3 busy for ten cycles with a second request queued behind the held one.
    a_if.bank_busy = 4'b1000;
    req(0, 1'b1, 10'h0E9, 4'hA, 1, 8'h08, 10'h29);
    req(0, 1'b1, 10'h010, 4'hB, 1, 8'h01, 10'h10);
    wait_a_pops(1);
    p = a_pops[0];
    repeat (5) step();
    check("t5_cycle", 32'(cyc - p), 32'd5);
    check("t5_stall_before", 32'(a_if.stall_err), 32'd0);
    check("t5_rinc_in_hold", 32'(a_if.fifo_rinc), 32'd0);
    check("t5_busy_in_hold", 32'(a_if.router_busy), 32'd1);
    step();
    check("t5_stall_set", 32'(a_if.stall_err), 32'd1);
    repeat (3) step();
    check("t5_no_issue_yet", 32'(a_issues.size()), 32'd0);
    a_if.bank_busy = '0;
    b = cyc;
    wait_a_issues(2);
    check("t5_release_issue", 32'(a_issues[0] - b), 32'd1);
    check("t5_follower_issue", 32'(a_issues[1] - b), 32'd3);
    repeat (3) step();
    check("t5_stall_sticky", 32'(a_if.stall_err), 32'd1);
    clear_logs();

    // 8-bank instance: async reset while an entry sits in HOLD, then a fresh request.
    b_if.bank_busy = 8'h80;
    req(1, 1'b1, 10'h3C1, 4'd2, 0, 8'h00, 10'h000);
    wait_b_pops(1);
    repeat (3) step();
    check("t6_busy_in_hold", 32'(b_if.router_busy), 32'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("t6_rst_bank_valid",  32'(b_if.bank_valid),  32'd0);
    check("t6_rst_router_busy", 32'(b_if.router_busy), 32'd0);
    check("t6_rst_req_drop",    32'(b_if.req_drop),    32'd0);
    check("t6_rst_stall_err",   32'(b_if.stall_err),   32'd0);
    check("t6_rst_fifo_rinc",   32'(b_if.fifo_rinc),   32'd0);
    check("t6_rst_a_stall_err", 32'(a_if.stall_err),   32'd0);
    check("t6_rst_a_bank_addr", 32'(a_if.bank_addr),   32'd0);
    check("t6_rst_a_bank_tag",  32'(a_if.bank_tag),    32'd0);
    b_if.bank_busy = '0;
    repeat (2) step();
    clear_logs();
    @(posedge clk);
    #2 reset = 1'b1;
    req(1, 1'b1, 10'h3FF, 4'hF, 1, 8'h80, 10'h7F);
    wait_b_issues(1);
    check("t6_latency", 32'(b_issues[0] - b_pops[0]), 32'd2);
    repeat (3) step();

    check("a_scoreboard_empty", 32'(a_exp.size()), 32'd0);
    check("b_scoreboard_empty", 32'(b_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
